riscv_div_seq: RTL and testbench
================================

Name: riscv_div_seq

Overview:
- Parametrised multi-cycle integer divider/remainder unit for the RI5CY EX stage.
- Serves ALU_DIVU/ALU_DIV/ALU_REMU/ALU_REM. operator_i is the low two bits of the ALU operator: bit0 selects signed, bit1 selects remainder.
- Generalises the fixed 32-bit divide to any WIDTH, using a valid/ready handshake on both input and output.
- Sits beside riscv_alu. The ID stage stalls while in_ready_o is low or a result is still pending.

Parameters:
- WIDTH, 32, operand/result width in bits; legal range 8..64.
- CNT_W, $clog2(WIDTH+1), iteration counter width; derived, do not override.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- operator_i  in  2  bit0=signed, bit1=remainder (00 DIVU, 01 DIV, 10 REMU, 11 REM)
- op_a_i  in  WIDTH  dividend
- op_b_i  in  WIDTH  divisor
- in_valid_i  in  1  operation request
- in_ready_o  out  1  unit can accept a request
- result_o  out  WIDTH  quotient or remainder
- out_valid_o  out  1  result_o valid
- out_ready_i  in  1  consumer takes result

Behaviour:
- Reset: clk is the only clock; rst is synchronous and active-high. On rst=1 at a clk edge:
  - state=IDLE, out_valid_o=0, result_o=0, in_ready_o=1, counter=0.
  - Reset has priority over every other event and aborts any operation in flight with no output.
- State machine: IDLE, DIV, FIX, DONE.
- IDLE:
  - in_ready_o=1.
  - An edge with in_valid_i=1 is the accept edge. On it: latch operator_i, |op_a_i|, |op_b_i| (absolute value only when signed), the sign of op_a_i, the sign of op_a_i XOR op_b_i, and the raw op_a_i.
  - Clear the partial remainder, load counter=WIDTH, go to DIV.
- DIV:
  - One restoring shift-subtract step per cycle, MSB first; the counter decrements each cycle.
  - The step at counter==1 is the last, then go to FIX. This is exactly WIDTH cycles.
- FIX:
  - Apply sign correction: negate the quotient if the operand signs differed, negate the remainder if the dividend was negative.
  - Select quotient or remainder into result_o, set out_valid_o=1, go to DONE.
- DONE:
  - Hold result_o and out_valid_o stable until an edge with out_ready_i=1.
  - On that edge: out_valid_o=0, go to IDLE.
- Latency: out_valid_o rises exactly WIDTH+2 edges after the accept edge (WIDTH=32 gives 34).
- in_ready_o=1 only in IDLE. A new request cannot be accepted on the same edge that the result is consumed; the next accept is possible one cycle later.
- Divide by zero (op_b_i==0):
  - Quotient is all ones; remainder is op_a_i unchanged, for both signed and unsigned.
  - Timing is the normal WIDTH+2 edges unless DIV_ZERO_FAST_EN is defined.
- Signed overflow (op_a_i = most-negative value, op_b_i = -1, signed): quotient = most-negative value, remainder = 0. No exception is raised.
- Width rules:
  - Absolute values are computed in WIDTH+1 bits so the most-negative value is represented correctly.
  - The partial remainder is WIDTH+1 bits.
  - All results are truncated to WIDTH bits.
- Input stability: op_a_i, op_b_i and operator_i are sampled only on the accept edge; changes afterwards have no effect.
- X-safety: result_o must never be X in DONE for known inputs.

Optional Feature:
- Macro: DIV_ZERO_FAST_EN.
- Defined:
  - In IDLE, an accepted request with op_b_i==0 skips DIV and FIX.
  - result_o is loaded with the divide-by-zero value, out_valid_o rises on the next edge (latency 1), and state goes to DONE.
  - The overflow case still uses the full latency.
- Not defined: divide by zero takes the normal WIDTH+2 edge path with identical results.

Test Plan:
- WIDTH=32, DIVU, a=100, b=7 -> out_valid_o after 34 edges, result_o=14; REMU same operands -> result_o=2.
- WIDTH=32, DIV, a=-100 (0xFFFFFF9C), b=7 -> result_o=0xFFFFFFF2 (-14); REM same operands -> 0xFFFFFFFE (-2).
- Divide by zero:
  - DIVU a=5, b=0 -> 0xFFFFFFFF; REM a=-5, b=0 -> 0xFFFFFFFB.
  - Latency is 34 edges without DIV_ZERO_FAST_EN and 1 edge with it.
- DIV a=0x80000000, b=0xFFFFFFFF -> result_o=0x80000000; REM same operands -> 0.
- Backpressure: hold out_ready_i=0 for 10 cycles after out_valid_o -> result_o stable and in_ready_o=0 throughout. Assert out_ready_i -> next cycle in_ready_o=1; a back-to-back request is accepted then.
- Reset mid-operation: assert rst at edge 15 of a DIV -> next cycle state=IDLE, out_valid_o=0, in_ready_o=1. A fresh WIDTH=8 instance doing DIVU 200/3 -> 66 after 10 edges.

Source files
------------

// File: rtl/riscv_div_seq.sv
// riscv_div_seq: multi-cycle restoring integer divider / remainder unit for the EX stage.
//
// Serves DIVU/DIV/REMU/REM. operator_i[0] selects signed, operator_i[1] selects remainder.
// One shift-subtract step per cycle on magnitudes, then a single sign-fix cycle.
//
// Ports:
//   clk          core clock
//   rst          synchronous active-high reset
//   operator_i   bit0 signed, bit1 remainder
//   op_a_i       dividend
//   op_b_i       divisor
//   in_valid_i   request valid
//   in_ready_o   unit idle, can accept a request
//   result_o     quotient or remainder
//   out_valid_o  result_o valid (held until out_ready_i)
//   out_ready_i  consumer takes the result
//
// Optional build macro DIV_ZERO_FAST_EN: divide-by-zero requests skip the iteration and
// produce their result one edge after acceptance. Undefined: they take the normal path.
module riscv_div_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       operator_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [WIDTH-1:0] result_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
);

  typedef enum logic [1:0] {StIdle, StDiv, StFix, StDone} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;      // partial remainder (always < divisor)
  logic [WIDTH-1:0]   quo_q, quo_d;      // dividend bits shift out, quotient bits shift in
  logic [WIDTH:0]     dvsr_q, dvsr_d;    // |divisor|
  logic [WIDTH-1:0]   a_raw_q, a_raw_d;
  logic               is_rem_q, is_rem_d;
  logic               a_neg_q, a_neg_d;
  logic               sign_diff_q, sign_diff_d;
  logic               b_zero_q, b_zero_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               out_valid_q, out_valid_d;

  logic               a_neg_in, b_neg_in;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH:0]     b_ext, abs_b;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH-1:0]   rem_sub;
  logic               ge;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  always_comb begin
    a_neg_in = operator_i[0] & op_a_i[WIDTH-1];
    b_neg_in = operator_i[0] & op_b_i[WIDTH-1];
    // Negation modulo 2^WIDTH read as unsigned is the exact magnitude, including the
    // most-negative value.
    abs_a    = a_neg_in ? -op_a_i : op_a_i;
    b_ext    = {b_neg_in, op_b_i};
    abs_b    = b_neg_in ? -b_ext : b_ext;

    rem_shift = {rem_q, quo_q[WIDTH-1]};
    ge        = (rem_shift >= dvsr_q);
    // When ge holds the difference is below the divisor, so the low bits are exact.
    rem_sub   = rem_shift[WIDTH-1:0] - dvsr_q[WIDTH-1:0];

    quo_fix = sign_diff_q ? -quo_q : quo_q;
    rem_fix = a_neg_q ? -rem_q : rem_q;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvsr_d      = dvsr_q;
    a_raw_d     = a_raw_q;
    is_rem_d    = is_rem_q;
    a_neg_d     = a_neg_q;
    sign_diff_d = sign_diff_q;
    b_zero_d    = b_zero_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid_i) begin
          is_rem_d    = operator_i[1];
          a_neg_d     = a_neg_in;
          sign_diff_d = a_neg_in ^ b_neg_in;
          b_zero_d    = (op_b_i == '0);
          a_raw_d     = op_a_i;
          quo_d       = abs_a;
          dvsr_d      = abs_b;
          rem_d       = '0;
          cnt_d       = CNT_W'(WIDTH);
          state_d     = StDiv;
`ifdef DIV_ZERO_FAST_EN
          if (op_b_i == '0) begin
            result_d    = operator_i[1] ? op_a_i : '1;
            out_valid_d = 1'b1;
            state_d     = StDone;
          end
`endif
        end
      end
      StDiv: begin
        rem_d = ge ? rem_sub : rem_shift[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], ge};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = StFix;
      end
      StFix: begin
        // Divide-by-zero bypasses sign correction: all-ones quotient, raw dividend remainder.
        if (b_zero_q) result_d = is_rem_q ? a_raw_q : '1;
        else          result_d = is_rem_q ? rem_fix : quo_fix;
        out_valid_d = 1'b1;
        state_d     = StDone;
      end
      StDone: begin
        if (out_ready_i) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvsr_q      <= '0;
      a_raw_q     <= '0;
      is_rem_q    <= 1'b0;
      a_neg_q     <= 1'b0;
      sign_diff_q <= 1'b0;
      b_zero_q    <= 1'b0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvsr_q      <= dvsr_d;
      a_raw_q     <= a_raw_d;
      is_rem_q    <= is_rem_d;
      a_neg_q     <= a_neg_d;
      sign_diff_q <= sign_diff_d;
      b_zero_q    <= b_zero_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready_o  = (state_q == StIdle);
  assign result_o    = result_q;
  assign out_valid_o = out_valid_q;

endmodule

// File: tb/tb_riscv_div_seq.sv
// Self-checking bench for riscv_div_seq: a WIDTH=32 instance checked every cycle by a
// monitor against an arithmetic model, plus a WIDTH=8 instance driven directly.
module tb_riscv_div_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  operator = 2'b00;
  logic [31:0] op_a = '0, op_b = '0;
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic        in_ready, out_valid;
  logic [31:0] result;

  logic [1:0]  d8_op = 2'b00;
  logic [7:0]  d8_a = '0, d8_b = '0;
  logic        d8_in_valid = 1'b0;
  logic        d8_out_ready = 1'b1;
  logic        d8_in_ready, d8_out_valid;
  logic [7:0]  d8_result;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  riscv_div_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .operator_i(operator), .op_a_i(op_a), .op_b_i(op_b),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .result_o(result),
    .out_valid_o(out_valid), .out_ready_i(out_ready)
  );

  riscv_div_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .operator_i(d8_op), .op_a_i(d8_a), .op_b_i(d8_b),
    .in_valid_i(d8_in_valid), .in_ready_o(d8_in_ready), .result_o(d8_result),
    .out_valid_o(d8_out_valid), .out_ready_i(d8_out_ready)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // RISC-V division semantics on w-bit operands, using 64-bit host arithmetic.
  function automatic logic [63:0] model(input int w, input logic [1:0] op,
                                        input logic [63:0] a_in, input logic [63:0] b_in);
    logic [63:0] mask, a, b, r;
    longint sa, sb;
    mask = (64'd1 << w) - 64'd1;
    a = a_in & mask;
    b = b_in & mask;
    if (b == 64'd0) begin
      r = op[1] ? a : '1;
    end else if (op[0]) begin
      sa = $signed(a << (64 - w)) >>> (64 - w);
      sb = $signed(b << (64 - w)) >>> (64 - w);
      r = op[1] ? 64'(sa % sb) : 64'(sa / sb);
    end else begin
      r = op[1] ? (a % b) : (a / b);
    end
    return r & mask;
  endfunction

  function automatic int exp_lat(input int w, input logic [63:0] b);
`ifdef DIV_ZERO_FAST_EN
    if (b == 64'd0) return 1;
`endif
    return w + 2;
  endfunction

  typedef struct {
    logic [63:0] exp;
    int          acc;
    int          lat;
  } txn_t;

  txn_t q[$];
  bit   seen = 1'b0;
  bit   chk_idle = 1'b0;
  bit   rst_seen = 1'b0;

  // Monitor: samples on the falling edge; inputs change 1 time unit after the rising edge.
  always @(negedge clk) begin
    if (chk_idle) begin
      check("ready_after_take", 64'(in_ready), 64'd1);
      check("valid_after_take", 64'(out_valid), 64'd0);
      chk_idle = 1'b0;
    end
    if (rst_seen) begin
      check("rst_ready", 64'(in_ready), 64'd1);
      check("rst_valid", 64'(out_valid), 64'd0);
      check("rst_result", 64'(result), 64'd0);
      rst_seen = 1'b0;
    end
    if (rst) begin
      q.delete();
      seen = 1'b0;
      rst_seen = 1'b1;
    end else begin
      if (out_valid) begin
        if (q.size() == 0) begin
          check("spurious_valid", 64'(out_valid), 64'd0);
        end else begin
          check("result", 64'(result), q[0].exp);
          check("busy_ready", 64'(in_ready), 64'd0);
          if (!seen) begin
            check("latency", 64'(cyc - q[0].acc + 1), 64'(q[0].lat));
            seen = 1'b1;
          end
          if (out_ready) begin
            void'(q.pop_front());
            seen = 1'b0;
            chk_idle = 1'b1;
          end
        end
      end
      if (in_valid && in_ready) begin
        txn_t t;
        t.exp = model(32, operator, {32'd0, op_a}, {32'd0, op_b});
        t.acc = cyc + 1;
        t.lat = exp_lat(32, {32'd0, op_b});
        q.push_back(t);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) check("timeout_in_ready", 64'(in_ready), 64'd1);
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold);
    int n = 0;
    wait_ready();
    in_valid = 1'b1;
    operator = op;
    op_a = a;
    op_b = b;
    step();
    // Scramble the inputs after acceptance; the unit must ignore them.
    in_valid = 1'b0;
    operator = 2'($urandom);
    op_a = $urandom;
    op_b = $urandom;
    while (!out_valid && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) begin
      check("timeout_out_valid", 64'(out_valid), 64'd1);
    end else begin
      repeat (hold) step();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end
  endtask

  task automatic run8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                      output logic [7:0] res);
    int n = 0;
    int cnt;
    res = '0;
    while (!d8_in_ready && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) check("w8_timeout_ready", 64'(d8_in_ready), 64'd1);
    d8_in_valid = 1'b1;
    d8_op = op;
    d8_a = a;
    d8_b = b;
    step();
    d8_in_valid = 1'b0;
    d8_a = 8'($urandom);
    d8_b = 8'($urandom);
    cnt = 1;
    while (!d8_out_valid && cnt < 60) begin
      step();
      cnt++;
    end
    if (cnt >= 60) begin
      check("w8_timeout_valid", 64'(d8_out_valid), 64'd1);
    end else begin
      res = d8_result;
      check("w8_result", 64'(d8_result), model(8, op, {56'd0, a}, {56'd0, b}));
      check("w8_latency", 64'(cnt), 64'(exp_lat(8, {56'd0, b})));
    end
    step();
  endtask

  initial begin
    logic [7:0]  r8;
    logic [31:0] ra, rb;

    // Pin the model against hand-computed values.
    check("m_divu", model(32, 2'b00, 64'd100, 64'd7), 64'd14);
    check("m_remu", model(32, 2'b10, 64'd100, 64'd7), 64'd2);
    check("m_div_neg", model(32, 2'b01, 64'hFFFF_FF9C, 64'd7), 64'hFFFF_FFF2);
    check("m_rem_neg", model(32, 2'b11, 64'hFFFF_FF9C, 64'd7), 64'hFFFF_FFFE);
    check("m_divu_zero", model(32, 2'b00, 64'd5, 64'd0), 64'hFFFF_FFFF);
    check("m_rem_zero", model(32, 2'b11, 64'hFFFF_FFFB, 64'd0), 64'hFFFF_FFFB);
    check("m_div_ovf", model(32, 2'b01, 64'h8000_0000, 64'hFFFF_FFFF), 64'h8000_0000);
    check("m_rem_ovf", model(32, 2'b11, 64'h8000_0000, 64'hFFFF_FFFF), 64'd0);
    check("m_w8_divu", model(8, 2'b00, 64'd200, 64'd3), 64'd66);

    repeat (3) step();
    rst = 1'b0;
    step();

    // Directed cases; the first one holds the result under backpressure for 10 cycles.
    run_op(2'b00, 32'd100, 32'd7, 10);
    run_op(2'b10, 32'd100, 32'd7, 0);
    run_op(2'b01, 32'hFFFF_FF9C, 32'd7, 1);
    run_op(2'b11, 32'hFFFF_FF9C, 32'd7, 0);
    run_op(2'b00, 32'd5, 32'd0, 2);
    run_op(2'b11, 32'hFFFF_FFFB, 32'd0, 0);
    run_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 3);
    run_op(2'b10, 32'd5, 32'd0, 0);
    run_op(2'b01, 32'd7, 32'd0, 0);

    // Reset lands on the 15th edge counting the accept edge as the first.
    wait_ready();
    in_valid = 1'b1;
    operator = 2'b01;
    op_a = 32'hDEAD_BEEF;
    op_b = 32'd7;
    step();
    in_valid = 1'b0;
    repeat (13) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();

    // Randomised traffic with corner-case bias.
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        3: rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 7));
        default: ;
      endcase
      run_op(2'($urandom), ra, rb, $urandom_range(0, 3));
    end

    // WIDTH=8 instance.
    run8(2'b00, 8'd200, 8'd3, r8);
    check("w8_lit_200_3", 64'(r8), 64'd66);
    run8(2'b11, 8'h80, 8'hFF, r8);
    check("w8_lit_rem_ovf", 64'(r8), 64'd0);
    for (int i = 0; i < 20; i++) begin
      run8(2'($urandom), 8'($urandom), 8'($urandom_range(0, 255) >> $urandom_range(0, 7)), r8);
    end

    repeat (5) step();
    check("queue_drained", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
